// File: rtl/mem_stage.sv
// Memory-access stage: samples synchronous SRAM read data, extracts/extends load data by size,
// and forwards the write-back value. A one-entry buffer holds load data across write-back stalls.
module mem_stage #(
  parameter int unsigned EXE_TO_MEM_BUS_WD = 74,
  parameter int unsigned MEM_TO_WB_BUS_WD  = 70
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         exe_to_mem_valid,
  input  logic [EXE_TO_MEM_BUS_WD-1:0] exe_to_mem_bus,
  output logic                         mem_allowin,
  input  logic [31:0]                  data_sram_rdata,
  input  logic                         wb_allowin,
  output logic                         mem_to_wb_valid,
  output logic [MEM_TO_WB_BUS_WD-1:0]  mem_to_wb_bus,
  output logic                         gr_we_mem,
  output logic [4:0]                   dest_mem,
  output logic [31:0]                  mem_fwd_data,
  output logic                         mem_is_load
);

  logic                         mem_valid_q, mem_valid_d;
  logic                         mem_first_q, mem_first_d;
  logic                         buf_valid_q, buf_valid_d;
  logic [EXE_TO_MEM_BUS_WD-1:0] bus_q, bus_d;
  logic [31:0]                  rdata_buf_q, rdata_buf_d;

  logic        load_op;
  logic [2:0]  ld_type;
  logic        gr_we;
  logic [4:0]  dest;
  logic [31:0] alu_result;
  logic [31:0] pc;

  assign load_op    = bus_q[73];
  assign ld_type    = bus_q[72:70];
  assign gr_we      = bus_q[69];
  assign dest       = bus_q[68:64];
  assign alu_result = bus_q[63:32];
  assign pc         = bus_q[31:0];

  // The stage never holds an instruction back on its own, so ready_go is constant 1.
  assign mem_allowin     = !mem_valid_q || wb_allowin;
  assign mem_to_wb_valid = mem_valid_q;

  always_comb begin
    mem_valid_d = mem_valid_q;
    mem_first_d = mem_first_q;
    buf_valid_d = buf_valid_q;
    bus_d       = bus_q;
    rdata_buf_d = rdata_buf_q;
    if (mem_allowin) begin
      mem_valid_d = exe_to_mem_valid;
      mem_first_d = exe_to_mem_valid;
      buf_valid_d = 1'b0;
      if (exe_to_mem_valid) begin
        bus_d = exe_to_mem_bus;
      end
    end else begin
      mem_first_d = 1'b0;
      // SRAM data is only valid in the first occupied cycle; keep it if we cannot drain.
      if (mem_valid_q && mem_first_q) begin
        rdata_buf_d = data_sram_rdata;
        buf_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      mem_valid_q <= 1'b0;
      mem_first_q <= 1'b0;
      buf_valid_q <= 1'b0;
      bus_q       <= '0;
      rdata_buf_q <= '0;
    end else begin
      mem_valid_q <= mem_valid_d;
      mem_first_q <= mem_first_d;
      buf_valid_q <= buf_valid_d;
      bus_q       <= bus_d;
      rdata_buf_q <= rdata_buf_d;
    end
  end

  logic [31:0] raw;
  logic [1:0]  off;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_data;
  logic [31:0] final_result;

  assign raw = buf_valid_q ? rdata_buf_q : data_sram_rdata;
  assign off = alu_result[1:0];

  always_comb begin
    byte_sel = raw[7:0];
    unique case (off)
      2'd0: byte_sel = raw[7:0];
      2'd1: byte_sel = raw[15:8];
      2'd2: byte_sel = raw[23:16];
      2'd3: byte_sel = raw[31:24];
      default: byte_sel = raw[7:0];
    endcase
  end

  assign half_sel = off[1] ? raw[31:16] : raw[15:0];

  always_comb begin
    load_data = raw;
    case (ld_type)
      3'b001:  load_data = {{24{byte_sel[7]}}, byte_sel};
      3'b101:  load_data = {24'd0, byte_sel};
      3'b010:  load_data = {{16{half_sel[15]}}, half_sel};
      3'b110:  load_data = {16'd0, half_sel};
      default: load_data = raw;
    endcase
  end

  assign final_result = load_op ? load_data : alu_result;

  assign mem_to_wb_bus = {gr_we, dest, final_result, pc};
  assign gr_we_mem     = mem_valid_q && gr_we;
  assign dest_mem      = mem_valid_q ? dest : 5'd0;
  assign mem_fwd_data  = final_result;
  assign mem_is_load   = mem_valid_q && load_op;

endmodule

// File: tb/tb_mem_stage.sv
// Directed-vector bench for mem_stage: reset, ALU pass-through, load extraction, stall capture,
// drain+accept and hazard outputs.
module tb_mem_stage;

  logic        clk;
  logic        resetn;
  logic        exe_to_mem_valid;
  logic [73:0] exe_to_mem_bus;
  logic        mem_allowin;
  logic [31:0] data_sram_rdata;
  logic        wb_allowin;
  logic        mem_to_wb_valid;
  logic [69:0] mem_to_wb_bus;
  logic        gr_we_mem;
  logic [4:0]  dest_mem;
  logic [31:0] mem_fwd_data;
  logic        mem_is_load;

  int n_checks = 0;
  int n_errors = 0;

  mem_stage #(
    .EXE_TO_MEM_BUS_WD(74),
    .MEM_TO_WB_BUS_WD (70)
  ) dut (
    .clk             (clk),
    .resetn          (resetn),
    .exe_to_mem_valid(exe_to_mem_valid),
    .exe_to_mem_bus  (exe_to_mem_bus),
    .mem_allowin     (mem_allowin),
    .data_sram_rdata (data_sram_rdata),
    .wb_allowin      (wb_allowin),
    .mem_to_wb_valid (mem_to_wb_valid),
    .mem_to_wb_bus   (mem_to_wb_bus),
    .gr_we_mem       (gr_we_mem),
    .dest_mem        (dest_mem),
    .mem_fwd_data    (mem_fwd_data),
    .mem_is_load     (mem_is_load)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [73:0] mk_bus(input logic load_op, input logic [2:0] ld_type,
                                         input logic gr_we, input logic [4:0] dest,
                                         input logic [31:0] alu, input logic [31:0] pc);
    return {load_op, ld_type, gr_we, dest, alu, pc};
  endfunction

  // Advance past the next rising edge, then let combinational outputs settle.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [2:0]  ld_type;
    logic [1:0]  off;
    logic [31:0] exp;
  } ld_vec_t;

  ld_vec_t ld_vecs[7];

  initial begin
    ld_vecs[0] = '{3'b001, 2'd1, 32'hFFFF_FFF2};
    ld_vecs[1] = '{3'b101, 2'd3, 32'h0000_0080};
    ld_vecs[2] = '{3'b010, 2'd2, 32'hFFFF_8081};
    ld_vecs[3] = '{3'b110, 2'd0, 32'h0000_F2F3};
    ld_vecs[4] = '{3'b000, 2'd0, 32'h8081_F2F3};
    ld_vecs[5] = '{3'b110, 2'd3, 32'h0000_8081};
    ld_vecs[6] = '{3'b011, 2'd1, 32'h8081_F2F3};

    resetn           = 1'b0;
    exe_to_mem_valid = 1'b1;
    exe_to_mem_bus   = mk_bus(1'b1, 3'b000, 1'b1, 5'd9, 32'h55, 32'h1c00_0000);
    wb_allowin       = 1'b1;
    data_sram_rdata  = 32'h0;

    // Reset with an accept pending
    step();
    step();
    check_eq("rst_valid", {31'd0, mem_to_wb_valid}, 32'd0);
    check_eq("rst_dest", {27'd0, dest_mem}, 32'd0);
    check_eq("rst_gr_we", {31'd0, gr_we_mem}, 32'd0);
    check_eq("rst_allowin", {31'd0, mem_allowin}, 32'd1);
    check_eq("rst_is_load", {31'd0, mem_is_load}, 32'd0);
    resetn           = 1'b1;
    exe_to_mem_valid = 1'b0;
    step();

    // Back-to-back ALU ops
    exe_to_mem_valid = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      exe_to_mem_bus = mk_bus(1'b0, 3'b000, 1'b1, 5'(i), 32'(i * 'h11), 32'h1c00_0100 + 32'(4 * i));
      step();
      check_eq($sformatf("alu%0d_res", i), mem_fwd_data, 32'(i * 'h11));
      check_eq($sformatf("alu%0d_valid", i), {31'd0, mem_to_wb_valid}, 32'd1);
    end
    check_eq("alu3_bus_res", mem_to_wb_bus[63:32], 32'h33);
    check_eq("alu3_bus_pc", mem_to_wb_bus[31:0], 32'h1c00_010c);
    check_eq("alu3_bus_dest", {27'd0, mem_to_wb_bus[68:64]}, 32'd3);
    exe_to_mem_valid = 1'b0;
    step();
    check_eq("alu_empty_valid", {31'd0, mem_to_wb_valid}, 32'd0);

    // Load extraction, one load per cycle
    data_sram_rdata = 32'h8081_F2F3;
    for (int i = 0; i < 7; i++) begin
      exe_to_mem_valid = 1'b1;
      exe_to_mem_bus   = mk_bus(1'b1, ld_vecs[i].ld_type, 1'b1, 5'd4,
                                {30'h0004_0000, ld_vecs[i].off}, 32'h1c00_0200);
      step();
      check_eq($sformatf("ld%0d_type%b_off%0d", i, ld_vecs[i].ld_type, ld_vecs[i].off),
               mem_fwd_data, ld_vecs[i].exp);
    end
    // Non-load with nonzero ld_type must pass alu_result through
    exe_to_mem_bus = mk_bus(1'b0, 3'b001, 1'b1, 5'd4, 32'h0000_1235, 32'h1c00_0204);
    step();
    check_eq("alu_not_load", mem_fwd_data, 32'h0000_1235);
    exe_to_mem_valid = 1'b0;
    step();

    // Stall capture: SRAM data changes while write-back is blocked
    exe_to_mem_valid = 1'b1;
    exe_to_mem_bus   = mk_bus(1'b1, 3'b000, 1'b1, 5'd8, 32'h0000_1000, 32'h1c00_0300);
    wb_allowin       = 1'b0;
    step();
    data_sram_rdata  = 32'hDEAD_BEEF;
    exe_to_mem_bus   = mk_bus(1'b0, 3'b000, 1'b1, 5'd9, 32'h99, 32'h1c00_0304);
    #1;
    check_eq("stall_c1_res", mem_fwd_data, 32'hDEAD_BEEF);
    check_eq("stall_c1_allowin", {31'd0, mem_allowin}, 32'd0);
    for (int c = 2; c <= 3; c++) begin
      step();
      data_sram_rdata = 32'h1234_5678 + 32'(c);
      #1;
      check_eq($sformatf("stall_c%0d_res", c), mem_fwd_data, 32'hDEAD_BEEF);
      check_eq($sformatf("stall_c%0d_allowin", c), {31'd0, mem_allowin}, 32'd0);
      check_eq($sformatf("stall_c%0d_valid", c), {31'd0, mem_to_wb_valid}, 32'd1);
    end
    step();
    wb_allowin = 1'b1;
    #1;
    check_eq("stall_release_allowin", {31'd0, mem_allowin}, 32'd1);
    check_eq("stall_release_res", mem_fwd_data, 32'hDEAD_BEEF);
    step();
    check_eq("stall_next_res", mem_fwd_data, 32'h99);
    exe_to_mem_valid = 1'b0;
    step();

    // Drain + accept on the same edge; the new load must not reuse the buffer
    exe_to_mem_valid = 1'b1;
    exe_to_mem_bus   = mk_bus(1'b1, 3'b000, 1'b1, 5'd10, 32'h0000_2000, 32'h1c00_0400);
    wb_allowin       = 1'b0;
    step();
    data_sram_rdata  = 32'hAAAA_5555;
    exe_to_mem_bus   = mk_bus(1'b1, 3'b101, 1'b1, 5'd11, 32'h0000_2004, 32'h1c00_0404);
    #1;
    check_eq("da_first_res", mem_fwd_data, 32'hAAAA_5555);
    step();
    data_sram_rdata = 32'h1111_1111;
    #1;
    check_eq("da_stalled_res", mem_fwd_data, 32'hAAAA_5555);
    wb_allowin = 1'b1;
    #1;
    check_eq("da_release_res", mem_fwd_data, 32'hAAAA_5555);
    step();
    data_sram_rdata  = 32'h0000_00C3;
    exe_to_mem_valid = 1'b0;
    #1;
    check_eq("da_next_res", mem_fwd_data, 32'h0000_00C3);
    check_eq("da_next_pc", mem_to_wb_bus[31:0], 32'h1c00_0404);
    step();

    // Hazard outputs
    exe_to_mem_valid = 1'b1;
    exe_to_mem_bus   = mk_bus(1'b1, 3'b000, 1'b1, 5'd7, 32'h0000_3000, 32'h1c00_0500);
    step();
    exe_to_mem_valid = 1'b0;
    check_eq("hz_gr_we", {31'd0, gr_we_mem}, 32'd1);
    check_eq("hz_dest", {27'd0, dest_mem}, 32'd7);
    check_eq("hz_is_load", {31'd0, mem_is_load}, 32'd1);
    step();
    check_eq("hz_empty_gr_we", {31'd0, gr_we_mem}, 32'd0);
    check_eq("hz_empty_dest", {27'd0, dest_mem}, 32'd0);
    check_eq("hz_empty_is_load", {31'd0, mem_is_load}, 32'd0);
    check_eq("hz_empty_valid", {31'd0, mem_to_wb_valid}, 32'd0);

    // Reset mid-stall discards the occupant
    exe_to_mem_valid = 1'b1;
    wb_allowin       = 1'b0;
    step();
    exe_to_mem_valid = 1'b0;
    step();
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    check_eq("rst_stall_valid", {31'd0, mem_to_wb_valid}, 32'd0);
    check_eq("rst_stall_allowin", {31'd0, mem_allowin}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
